// File: rtl/conv3x3_engine.sv
// rtl/conv3x3_engine.sv - streaming dual-kernel 3x3 convolution from BRAM0 to BRAM1
// Purpose: reads a raster image (one PIX_W pixel per 32-bit word) from BRAM0, applies two
//   runtime signed 3x3 kernels and writes one saturated result per pixel to BRAM1.
// Ports: clk/rst_n (async active-low), start/done/busy handshake, cfg_* frame configuration
//   (latched when a frame is launched), bram0_* read port (1-cycle read latency),
//   bram1_* write port (byte address, word data, 4-bit write enable).
module conv3x3_engine #(
  parameter int MAX_W  = 1024,
  parameter int MAX_H  = 1024,
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         done,
  output logic                         busy,
  input  logic [$clog2(MAX_W+1)-1:0]   cfg_width,
  input  logic [$clog2(MAX_H+1)-1:0]   cfg_height,
  input  logic [1:0]                   cfg_mode,
  input  logic                         cfg_border,
  input  logic [3:0]                   cfg_shift,
  input  logic [9*COEF_W-1:0]          cfg_k0,
  input  logic [9*COEF_W-1:0]          cfg_k1,
  output logic [31:0]                  bram0_addr,
  input  logic [31:0]                  bram0_dout,
  output logic                         bram0_en,
  output logic [31:0]                  bram1_addr,
  output logic [31:0]                  bram1_din,
  output logic [3:0]                   bram1_we
);
  localparam int XW = $clog2(MAX_W+1);
  localparam int YW = $clog2(MAX_H+1);
  localparam int CW = ((XW > YW) ? XW : YW) + 2;
  localparam int PW = PIX_W + COEF_W + 1;
  localparam int SW = PIX_W + COEF_W + 5;
  localparam int AW = SW + 1;
  localparam logic [AW-1:0] SAT = AW'({PIX_W{1'b1}});

  typedef enum logic [2:0] {S_IDLE, S_READ9, S_READ3, S_MUL, S_ACC, S_WRITE, S_DONE} state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [XW-1:0] x_q, x_d, w_q;
  logic [YW-1:0] y_q, y_d, h_q;
  logic [1:0] mode_q;
  logic border_q;
  logic [3:0] shift_q;
  logic [9*COEF_W-1:0] k0_q, k1_q;
  logic [PIX_W-1:0] win_q [9];
  logic signed [PW-1:0] p0_q [9];
  logic signed [PW-1:0] p1_q [9];
  logic signed [SW-1:0] s0_q, s1_q, rs0, rs1, sh;
  logic [PIX_W-1:0] res_q, res_d;
  logic oob1_q, oob2_q;
  logic last_x, issue, oob, cap;
  logic [1:0] r_off, c_off;
  logic [3:0] cap_tap, mbase;
  logic signed [CW-1:0] row_s, col_s;
  logic [YW-1:0] row_c;
  logic [XW-1:0] col_c;
  logic [31:0] rd_lin, wr_lin;
  logic [AW-1:0] a0, a1, v;
  logic unused_dout;

  assign unused_dout = ^bram0_dout[31:PIX_W];
  assign done     = (state_q == S_DONE);
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bram0_en = (state_q == S_READ9) || (state_q == S_READ3);

  function automatic logic signed [PW-1:0] mul(input logic [PIX_W-1:0] p, input logic [COEF_W-1:0] k);
    return PW'($signed({1'b0, p})) * PW'($signed(k));
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 4'd1;
    x_d     = x_q;
    y_d     = y_q;
    last_x  = (x_q == w_q - XW'(1));
    case (state_q)
      S_IDLE: begin
        cnt_d = 4'd0;
        if (start) begin
          x_d = '0;
          y_d = '0;
          state_d = (cfg_width == '0 || cfg_height == '0) ? S_DONE : S_READ9;
        end
      end
      S_READ9: if (cnt_q == 4'd10) begin state_d = S_MUL; cnt_d = 4'd0; end
      S_READ3: if (cnt_q == 4'd4) begin state_d = S_MUL; cnt_d = 4'd0; end
      // MUL walks one window row per cycle; ACC folds one row per cycle, then forms the result.
      S_MUL:   if (cnt_q == 4'd2) begin state_d = S_ACC; cnt_d = 4'd0; end
      S_ACC:   if (cnt_q == 4'd3) begin state_d = S_WRITE; cnt_d = 4'd0; end
      S_WRITE: begin
        cnt_d = 4'd0;
        if (last_x) begin
          x_d = '0;
          y_d = y_q + YW'(1);
          state_d = (y_q == h_q - YW'(1)) ? S_DONE : S_READ9;
        end else begin
          x_d = x_q + XW'(1);
          state_d = S_READ3;
        end
      end
      S_DONE: begin
        cnt_d = 4'd0;
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read address generation: window-relative row/col offset -> clamped in-range address,
  // plus an out-of-range flag that travels with the address to the capture point.
  always_comb begin
    issue = 1'b0;
    r_off = 2'd0;
    c_off = 2'd0;
    if (state_q == S_READ9 && cnt_q <= 4'd8) begin
      issue = 1'b1;
      r_off = 2'(cnt_q / 4'd3);
      c_off = 2'(cnt_q % 4'd3);
    end else if (state_q == S_READ3 && cnt_q <= 4'd2) begin
      issue = 1'b1;
      r_off = cnt_q[1:0];
      c_off = 2'd2;
    end
    row_s = $signed(CW'(y_q) + CW'(r_off) - CW'(1));
    col_s = $signed(CW'(x_q) + CW'(c_off) - CW'(1));
    oob = row_s[CW-1] || (row_s >= $signed(CW'(h_q))) || col_s[CW-1] || (col_s >= $signed(CW'(w_q)));
    if (row_s[CW-1])                        row_c = '0;
    else if (row_s >= $signed(CW'(h_q)))    row_c = h_q - YW'(1);
    else                                    row_c = row_s[YW-1:0];
    if (col_s[CW-1])                        col_c = '0;
    else if (col_s >= $signed(CW'(w_q)))    col_c = w_q - XW'(1);
    else                                    col_c = col_s[XW-1:0];
    rd_lin = 32'(row_c) * 32'(w_q) + 32'(col_c);
    wr_lin = 32'(y_q) * 32'(w_q) + 32'(x_q);
  end

  // Capture tap (data arrives two counts after its address), MUL/ACC row base, result.
  always_comb begin
    cap = 1'b0;
    cap_tap = 4'd0;
    if (state_q == S_READ9 && cnt_q >= 4'd2) begin
      cap = 1'b1;
      cap_tap = cnt_q - 4'd2;
    end else if (state_q == S_READ3 && cnt_q >= 4'd2) begin
      cap = 1'b1;
      cap_tap = 4'd3 * (cnt_q - 4'd2) + 4'd2;
    end
    mbase = (cnt_q >= 4'd3) ? 4'd6 : 4'd3 * cnt_q;
    rs0 = SW'(p0_q[mbase]) + SW'(p0_q[mbase + 4'd1]) + SW'(p0_q[mbase + 4'd2]);
    rs1 = SW'(p1_q[mbase]) + SW'(p1_q[mbase + 4'd1]) + SW'(p1_q[mbase + 4'd2]);
    a0 = s0_q[SW-1] ? AW'(-s0_q) : AW'(s0_q);
    a1 = s1_q[SW-1] ? AW'(-s1_q) : AW'(s1_q);
    sh = s0_q >>> shift_q;
    case (mode_q)
      2'd1:    v = a0;
      2'd2:    v = sh[SW-1] ? '0 : AW'(sh);
      default: v = a0 + a1;
    endcase
    res_d = (v > SAT) ? {PIX_W{1'b1}} : v[PIX_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= 4'd0;
      x_q <= '0;
      y_q <= '0;
      w_q <= '0;
      h_q <= '0;
      mode_q <= 2'd0;
      border_q <= 1'b0;
      shift_q <= 4'd0;
      k0_q <= '0;
      k1_q <= '0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
        p0_q[i] <= '0;
        p1_q[i] <= '0;
      end
      s0_q <= '0;
      s1_q <= '0;
      res_q <= '0;
      oob1_q <= 1'b0;
      oob2_q <= 1'b0;
      bram0_addr <= '0;
      bram1_addr <= '0;
      bram1_din <= '0;
      bram1_we <= 4'b0000;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      x_q <= x_d;
      y_q <= y_d;
      bram1_we <= 4'b0000;
      oob2_q <= oob1_q;
      if (state_q == S_IDLE && start) begin
        w_q <= cfg_width;
        h_q <= cfg_height;
        mode_q <= cfg_mode;
        border_q <= cfg_border;
        shift_q <= cfg_shift;
        k0_q <= cfg_k0;
        k1_q <= cfg_k1;
      end
      if (issue) begin
        bram0_addr <= {rd_lin[29:0], 2'b00};
        oob1_q <= oob;
      end
      if (cap) win_q[cap_tap] <= (!border_q && oob2_q) ? '0 : bram0_dout[PIX_W-1:0];
      if (state_q == S_MUL) begin
        for (int j = 0; j < 3; j++) begin
          p0_q[mbase + 4'(j)] <= mul(win_q[mbase + 4'(j)], k0_q[(mbase + 4'(j))*COEF_W +: COEF_W]);
          p1_q[mbase + 4'(j)] <= mul(win_q[mbase + 4'(j)], k1_q[(mbase + 4'(j))*COEF_W +: COEF_W]);
        end
      end
      if (state_q == S_ACC) begin
        if (cnt_q == 4'd0) begin
          s0_q <= rs0;
          s1_q <= rs1;
        end else if (cnt_q <= 4'd2) begin
          s0_q <= s0_q + rs0;
          s1_q <= s1_q + rs1;
        end else begin
          res_q <= res_d;
        end
      end
      if (state_q == S_WRITE) begin
        bram1_we <= 4'b1111;
        bram1_addr <= {wr_lin[29:0], 2'b00};
        bram1_din <= 32'(res_q);
        // Slide the window one column left; the next READ3 refills taps 2, 5, 8.
        for (int r = 0; r < 3; r++) begin
          win_q[3*r]     <= win_q[3*r + 1];
          win_q[3*r + 1] <= win_q[3*r + 2];
        end
      end
    end
  end
endmodule

// File: tb/tb_conv3x3_engine.sv
// tb/tb_conv3x3_engine.sv - self-checking bench for conv3x3_engine
module tb_conv3x3_engine;
  localparam int MAX_W = 1024;
  localparam int MAX_H = 1024;
  localparam int PIX_W = 8;
  localparam int COEF_W = 8;
  localparam int XW = $clog2(MAX_W+1);
  localparam int YW = $clog2(MAX_H+1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic done, busy, bram0_en;
  logic [XW-1:0] cfg_width = '0;
  logic [YW-1:0] cfg_height = '0;
  logic [1:0] cfg_mode = '0;
  logic cfg_border = 1'b0;
  logic [3:0] cfg_shift = '0;
  logic [9*COEF_W-1:0] cfg_k0 = '0;
  logic [9*COEF_W-1:0] cfg_k1 = '0;
  logic [31:0] bram0_addr, bram1_addr, bram1_din;
  logic [31:0] bram0_dout = '0;
  logic [3:0] bram1_we;

  int n_cmp = 0;
  int n_err = 0;
  int img [1024];
  int got [1024];
  int ka0 [9];
  int ka1 [9];
  int exp_addr [$];
  int exp_data [$];
  int n_wr = 0;
  int n_rd = 0;
  int n_busy = 0;
  int cur_w = 0;
  int cur_h = 0;
  int cur_n = 0;

  always #5 clk = ~clk;

  conv3x3_engine #(.MAX_W(MAX_W), .MAX_H(MAX_H), .PIX_W(PIX_W), .COEF_W(COEF_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done), .busy(busy),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_mode(cfg_mode),
    .cfg_border(cfg_border), .cfg_shift(cfg_shift), .cfg_k0(cfg_k0), .cfg_k1(cfg_k1),
    .bram0_addr(bram0_addr), .bram0_dout(bram0_dout), .bram0_en(bram0_en),
    .bram1_addr(bram1_addr), .bram1_din(bram1_din), .bram1_we(bram1_we)
  );

  task automatic check(string name, longint act, longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Source BRAM: registered address in, data out one edge later.
  always @(posedge clk) begin
    if (bram0_en) bram0_dout <= 32'(img[bram0_addr[11:2]]);
  end

  // Compare process: every write is matched against the model's raster-ordered queue.
  always @(negedge clk) begin
    if (busy) n_busy++;
    if (bram0_en) begin
      if (n_rd > 0)
        check("rd_addr_range", (bram0_addr < 32'(4*cur_w*cur_h)) && (bram0_addr[1:0] == 2'b00), 1);
      n_rd++;
    end
    if (bram1_we != 4'b0000) begin
      n_wr++;
      check("we_pattern", bram1_we, 4'hf);
      check("write_pending", exp_addr.size() != 0, 1);
      if (exp_addr.size() != 0) begin
        int ea, ed;
        ea = exp_addr.pop_front();
        ed = exp_data.pop_front();
        check($sformatf("wr_addr[%0d]", cur_n), bram1_addr, ea);
        check($sformatf("wr_data[%0d]", cur_n), bram1_din, ed);
        got[bram1_addr[11:2]] = int'(bram1_din);
        cur_n++;
      end
    end
  end

  function automatic int model_pix(int x, int y, int w, int h, int mode, int border, int shift);
    int s0, s1, r, c, rc, cc, p, v, a0, a1;
    s0 = 0;
    s1 = 0;
    for (int i = 0; i < 9; i++) begin
      r = y - 1 + i / 3;
      c = x - 1 + i % 3;
      rc = (r < 0) ? 0 : ((r >= h) ? h - 1 : r);
      cc = (c < 0) ? 0 : ((c >= w) ? w - 1 : c);
      p = ((r < 0 || r >= h || c < 0 || c >= w) && border == 0) ? 0 : img[rc*w + cc];
      s0 += p * ka0[i];
      s1 += p * ka1[i];
    end
    a0 = (s0 < 0) ? -s0 : s0;
    a1 = (s1 < 0) ? -s1 : s1;
    if (mode == 1)      v = a0;
    else if (mode == 2) begin v = s0 >>> shift; if (v < 0) v = 0; end
    else                v = a0 + a1;
    return (v > 255) ? 255 : v;
  endfunction

  task automatic setup(int w, int h, int mode, int border, int shift);
    exp_addr.delete();
    exp_data.delete();
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        exp_addr.push_back(4*(y*w + x));
        exp_data.push_back(model_pix(x, y, w, h, mode, border, shift));
      end
    for (int i = 0; i < 1024; i++) got[i] = -1;
    cfg_width = XW'(w);
    cfg_height = YW'(h);
    cfg_mode = 2'(mode);
    cfg_border = border[0];
    cfg_shift = 4'(shift);
    for (int i = 0; i < 9; i++) begin
      cfg_k0[i*COEF_W +: COEF_W] = ka0[i][COEF_W-1:0];
      cfg_k1[i*COEF_W +: COEF_W] = ka1[i][COEF_W-1:0];
    end
    cur_w = w;
    cur_h = h;
    cur_n = 0;
    n_wr = 0;
    n_rd = 0;
    n_busy = 0;
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    // Config is frozen once the frame is launched; scramble the inputs.
    cfg_width = ~cfg_width;
    cfg_height = ~cfg_height;
    cfg_mode = ~cfg_mode;
    cfg_border = ~cfg_border;
    cfg_shift = ~cfg_shift;
    cfg_k0 = ~cfg_k0;
    cfg_k1 = ~cfg_k1;
  endtask

  task automatic finish_frame(string tag);
    int i;
    i = 0;
    while (!done && i < 30000) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_done_reached"}, done, 1);
    repeat (4) @(negedge clk);
    check({tag, "_done_held"}, done, 1);
    check({tag, "_write_count"}, n_wr, cur_w*cur_h);
    check({tag, "_writes_left"}, exp_addr.size(), 0);
    start = 1'b0;
    @(negedge clk);
    check({tag, "_done_clear"}, done, 0);
    check({tag, "_busy_clear"}, busy, 0);
  endtask

  task automatic run_frame(string tag, int w, int h, int mode, int border, int shift);
    setup(w, h, mode, border, shift);
    launch();
    finish_frame(tag);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_bram0_en"}, bram0_en, 0);
    check({tag, "_bram0_addr"}, bram0_addr, 0);
    check({tag, "_bram1_addr"}, bram1_addr, 0);
    check({tag, "_bram1_din"}, bram1_din, 0);
    check({tag, "_bram1_we"}, bram1_we, 0);
  endtask

  task automatic fill_const(int n, int val);
    for (int i = 0; i < n; i++) img[i] = val;
  endtask

  initial begin
    int wr_before;
    for (int i = 0; i < 1024; i++) img[i] = 0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Sobel pair, flat image
    ka0 = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
    ka1 = '{1, 2, 1, 0, 0, 0, -1, -2, -1};
    fill_const(16, 100);
    run_frame("sobel_zero", 4, 4, 0, 0, 0);
    check("sobel_zero_corner", got[0], 255);
    check("sobel_zero_inner", got[5], 0);
    run_frame("sobel_clamp", 4, 4, 0, 1, 0);
    check("sobel_clamp_corner", got[0], 0);

    // Gaussian in mode 2
    ka0 = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    run_frame("gauss_clamp", 4, 4, 2, 1, 4);
    check("gauss_clamp_inner", got[5], 100);
    run_frame("gauss_zero", 4, 4, 2, 0, 4);
    check("gauss_zero_corner", got[0], 56);
    check("gauss_zero_edge", got[1], 75);

    // 8x3 horizontal ramp
    ka0 = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 8; x++) img[y*8 + x] = 10*x;
    run_frame("ramp", 8, 3, 0, 1, 0);
    check("ramp_left", got[8], 40);
    check("ramp_inner", got[11], 80);
    check("ramp_right", got[15], 40);
    check("ramp_cycles", n_busy, 330);
    run_frame("ramp_m2", 8, 3, 2, 0, 1);

    // Textured image, mode 1 and mode 3
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 6; x++) img[y*6 + x] = (x*37 + y*91) % 256;
    run_frame("tex_m1", 6, 5, 1, 0, 0);
    run_frame("tex_m3", 6, 5, 3, 1, 0);

    // Degenerate sizes
    ka0 = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    img[0] = 50;
    run_frame("one_px", 1, 1, 2, 0, 0);
    check("one_px_value", got[0], 50);
    run_frame("one_row", 5, 1, 0, 1, 0);
    run_frame("w0", 0, 4, 0, 0, 0);
    check("w0_reads", n_rd, 0);

    // Abort mid-frame with reset
    ka0 = '{1, 0, -1, 2, 0, -2, 1, 0, -1};
    for (int i = 0; i < 256; i++) img[i] = (i*13) % 256;
    setup(16, 16, 0, 0, 0);
    launch();
    repeat (200) @(negedge clk);
    check("abort_was_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    exp_addr.delete();
    exp_data.delete();
    start = 1'b0;
    wr_before = n_wr;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_no_writes", n_wr, wr_before);
    check("abort_idle", busy, 0);

    fill_const(16, 100);
    run_frame("after_reset", 4, 4, 3, 0, 0);
    check("after_reset_corner", got[0], 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
